jtag_link_arb: RTL and testbench

Arbitrates two byte-stream requesters (e.g. debug monitor and console) onto the single USB-JTAG byte transmitter, and routes received bytes back to the right requester. Sits between the CPU-side I/O devices and `usb_jtag`: drives its `iTxD_DATA`/`iTxD_Start`, consumes its `oTxD_Done`/`oRxD_DATA`/`oRxD_Ready`. Adds round-robin arbitration, inter-byte gap insertion, host-stall timeout, and optional in-band channel framing.

---
 rtl/jtag_link_pkg.sv | 19 +
 rtl/jtag_rx_deframer.sv | 62 ++++++
 rtl/jtag_link_arb.sv | 131 +++++++++++++
 tb/tb_jtag_link_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_link_pkg.sv
// Shared constants and types for the USB-JTAG link arbiter.
// Channel framing is compiled in when JTAG_ARB_FRAMING_EN is defined.
package jtag_link_pkg;
  localparam logic [7:0] ESC_BYTE = 8'hFE;
  localparam logic       CH0      = 1'b0;
  localparam logic       CH1      = 1'b1;

  typedef enum logic [2:0] {TX_IDLE, TX_ESC, TX_SEL, TX_DATA, TX_GAP} txState_t;

`ifdef JTAG_ARB_FRAMING_EN
  localparam bit FRAMING_EN = 1'b1;
`else
  localparam bit FRAMING_EN = 1'b0;
`endif

  function automatic int cntWidth(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction
endpackage

// File: rtl/jtag_rx_deframer.sv
// Routes received bytes to a requester channel; decodes FE escapes when
// JTAG_ARB_FRAMING_EN is defined, otherwise everything goes to channel 0.
module jtag_rx_deframer
  import jtag_link_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic [7:0] iRxD_DATA,
  input  logic       iRxD_Ready,
  output logic [7:0] oRx_DATA,
  output logic [1:0] oRx_Valid,
  output logic       oRx_Err
);
`ifdef JTAG_ARB_FRAMING_EN
  logic escFlag;
  logic rxCh;

  always_ff @(posedge iCLK) begin
    if (iRST_n) begin
      escFlag   <= 1'b0;
      rxCh      <= CH0;
      oRx_DATA  <= 8'h00;
      oRx_Valid <= 2'b00;
      oRx_Err   <= 1'b0;
    end else begin
      oRx_Valid <= 2'b00;
      oRx_Err   <= 1'b0;
      if (iRxD_Ready) begin
        if (escFlag) begin
          // Byte after an escape: channel select, literal FE, or garbage
          escFlag <= 1'b0;
          if (iRxD_DATA == {7'b0, CH0} || iRxD_DATA == {7'b0, CH1}) begin
            rxCh <= iRxD_DATA[0];
          end else if (iRxD_DATA == ESC_BYTE) begin
            oRx_DATA  <= iRxD_DATA;
            oRx_Valid <= {rxCh, ~rxCh};
          end else begin
            oRx_Err <= 1'b1;
          end
        end else if (iRxD_DATA == ESC_BYTE) begin
          escFlag <= 1'b1;
        end else begin
          oRx_DATA  <= iRxD_DATA;
          oRx_Valid <= {rxCh, ~rxCh};
        end
      end
    end
  end
`else
  assign oRx_Err = 1'b0;

  always_ff @(posedge iCLK) begin
    if (iRST_n) begin
      oRx_DATA  <= 8'h00;
      oRx_Valid <= 2'b00;
    end else begin
      oRx_Valid <= {1'b0, iRxD_Ready};
      if (iRxD_Ready) oRx_DATA <= iRxD_DATA;
    end
  end
`endif
endmodule

// File: rtl/jtag_link_arb.sv
// Round-robin arbiter of two byte requesters onto the usb_jtag transmitter,
// with inter-byte gap, stall timeout and (JTAG_ARB_FRAMING_EN) FE framing.
module jtag_link_arb
  import jtag_link_pkg::*;
#(
  parameter int TIMEOUT = 50_000_000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic [7:0] iCh0_DATA,
  input  logic [7:0] iCh1_DATA,
  input  logic       iCh0_Valid,
  input  logic       iCh1_Valid,
  output logic       oCh0_Ack,
  output logic       oCh1_Ack,
  output logic [7:0] oTxD_DATA,
  output logic       oTxD_Start,
  input  logic       iTxD_Done,
  input  logic [7:0] iRxD_DATA,
  input  logic       iRxD_Ready,
  output logic [7:0] oRx_DATA,
  output logic [1:0] oRx_Valid,
  output logic       oTimeout,
  output logic       oRx_Err
);
  localparam int            CW      = cntWidth(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  txState_t      state, stateNx, succ, succNx;
  logic          grantCh, grantNx, rrLast;
  logic [7:0]    dataLat, dataNx;
  logic          lastValid, lastCh;
  logic [CW-1:0] cnt;
  logic [1:0]    ackQ;
  logic          toQ;
  logic          sending, doneEv, toHit, grantEv, sameCh;

  assign sending = (state == TX_ESC) || (state == TX_SEL) || (state == TX_DATA);
  assign doneEv  = sending && iTxD_Done;
  assign toHit   = sending && !iTxD_Done && (cnt == CNT_MAX);
  assign grantEv = (state == TX_IDLE) && (iCh0_Valid || iCh1_Valid);
  assign grantNx = (iCh0_Valid && iCh1_Valid) ? ~rrLast : iCh1_Valid;
  assign dataNx  = grantNx ? iCh1_DATA : iCh0_DATA;
  assign sameCh  = lastValid && (lastCh == grantCh);

  always_ff @(posedge iCLK) begin
    if (iRST_n) begin
      state     <= TX_IDLE;
      succ      <= TX_IDLE;
      grantCh   <= CH0;
      dataLat   <= 8'h00;
      rrLast    <= CH1;
      lastValid <= 1'b0;
      lastCh    <= CH0;
      cnt       <= '0;
      ackQ      <= 2'b00;
      toQ       <= 1'b0;
    end else begin
      state <= stateNx;
      succ  <= succNx;
      if (grantEv) begin
        grantCh <= grantNx;
        dataLat <= dataNx;
        rrLast  <= grantNx;
      end
      cnt  <= (sending && stateNx == state) ? cnt + CW'(1) : '0;
      ackQ <= 2'b00;
      toQ  <= 1'b0;
      if (doneEv && state == TX_DATA) ackQ <= {grantCh, ~grantCh};
      if (doneEv && state == TX_SEL) begin
        lastValid <= 1'b1;
        lastCh    <= grantCh;
      end
      // Abort: forget what the host last saw so the next byte re-selects
      if (toHit) begin
        ackQ      <= {grantCh, ~grantCh};
        toQ       <= 1'b1;
        lastValid <= 1'b0;
      end
    end
  end

  always_comb begin
    stateNx = state;
    succNx  = succ;
    unique case (state)
      TX_IDLE:
        if (grantEv)
          stateNx = (FRAMING_EN && (!(lastValid && lastCh == grantNx) || dataNx == ESC_BYTE))
                    ? TX_ESC : TX_DATA;
      TX_ESC, TX_SEL, TX_DATA: begin
        if (doneEv) begin
          stateNx = TX_GAP;
          if (state == TX_ESC)      succNx = sameCh ? TX_DATA : TX_SEL;
          else if (state == TX_SEL) succNx = (dataLat == ESC_BYTE) ? TX_ESC : TX_DATA;
          else                      succNx = TX_IDLE;
        end else if (toHit) begin
          stateNx = TX_GAP;
          succNx  = TX_IDLE;
        end
      end
      TX_GAP:  stateNx = succ;
      default: stateNx = TX_IDLE;
    endcase
  end

  always_comb begin
    oTxD_Start = sending;
    oTxD_DATA  = 8'h00;
    unique case (state)
      TX_ESC:  oTxD_DATA = ESC_BYTE;
      TX_SEL:  oTxD_DATA = {7'b0, grantCh};
      TX_DATA: oTxD_DATA = dataLat;
      default: oTxD_DATA = 8'h00;
    endcase
  end

  assign oCh0_Ack = ackQ[0];
  assign oCh1_Ack = ackQ[1];
  assign oTimeout = toQ;

  jtag_rx_deframer uRx (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iRxD_DATA (iRxD_DATA),
    .iRxD_Ready(iRxD_Ready),
    .oRx_DATA  (oRx_DATA),
    .oRx_Valid (oRx_Valid),
    .oRx_Err   (oRx_Err)
  );
endmodule

// File: tb/tb_jtag_link_arb.sv
// Directed bench for jtag_link_arb; expectations follow JTAG_ARB_FRAMING_EN.
module tb_jtag_link_arb;
  localparam int TO = 24;

  logic       iCLK = 1'b0, iRST_n = 1'b1;
  logic [7:0] iCh0_DATA = 8'h00, iCh1_DATA = 8'h00;
  logic       iCh0_Valid = 1'b0, iCh1_Valid = 1'b0;
  logic       oCh0_Ack, oCh1_Ack;
  logic [7:0] oTxD_DATA;
  logic       oTxD_Start;
  logic       iTxD_Done = 1'b0;
  logic [7:0] iRxD_DATA = 8'h00;
  logic       iRxD_Ready = 1'b0;
  logic [7:0] oRx_DATA;
  logic [1:0] oRx_Valid;
  logic       oTimeout, oRx_Err;

  int nChk = 0, nPass = 0;

  jtag_link_arb #(.TIMEOUT(TO)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iCh0_DATA(iCh0_DATA), .iCh1_DATA(iCh1_DATA),
    .iCh0_Valid(iCh0_Valid), .iCh1_Valid(iCh1_Valid),
    .oCh0_Ack(oCh0_Ack), .oCh1_Ack(oCh1_Ack),
    .oTxD_DATA(oTxD_DATA), .oTxD_Start(oTxD_Start), .iTxD_Done(iTxD_Done),
    .iRxD_DATA(iRxD_DATA), .iRxD_Ready(iRxD_Ready),
    .oRx_DATA(oRx_DATA), .oRx_Valid(oRx_Valid),
    .oTimeout(oTimeout), .oRx_Err(oRx_Err)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, nPass=%0d nChk=%0d", nPass, nChk);
    $fatal(1);
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pulse_reset();
    iRST_n = 1'b1;
    tick();
    iRST_n = 1'b0;
  endtask

  // One wire byte: wait for Start, hold it `hold` cycles, return what was seen
  task automatic xfer(input int hold, output logic [7:0] dat, output int waitCyc,
                      output logic startOk, output logic [1:0] ack);
    waitCyc = 0; startOk = 1'b1; dat = 8'hxx; ack = 2'bxx;
    while (oTxD_Start !== 1'b1 && waitCyc < 60) begin tick(); waitCyc++; end
    if (oTxD_Start !== 1'b1) begin startOk = 1'b0; return; end
    dat = oTxD_DATA;
    for (int i = 1; i < hold; i++) begin
      tick();
      if (oTxD_Start !== 1'b1) startOk = 1'b0;
    end
    iTxD_Done = 1'b1;
    tick();
    iTxD_Done = 1'b0;
    if (oTxD_Start !== 1'b0) startOk = 1'b0;
    ack = {oCh1_Ack, oCh0_Ack};
  endtask

  task automatic test_reset();
    logic [22:0] outs;
    iRST_n = 1'b1;
    tick(); tick();
    outs = {oTxD_Start, oTxD_DATA, oCh1_Ack, oCh0_Ack, oRx_DATA, oRx_Valid, oTimeout, oRx_Err};
    nChk++;
    if (outs !== 23'd0) $display("FAIL reset outputs: got %h want 0", outs); else nPass++;
    iRST_n = 1'b0;
    iTxD_Done = 1'b1;
    tick();
    iTxD_Done = 1'b0;
    tick();
    nChk++;
    if ({oTxD_Start, oCh1_Ack, oCh0_Ack} !== 3'b000)
      $display("FAIL stray done: start/ack got %b want 000", {oTxD_Start, oCh1_Ack, oCh0_Ack});
    else nPass++;
  endtask

  task automatic test_single();
    logic [7:0] exp[$]; logic [7:0] d; int w; logic ok; logic [1:0] a;
`ifdef JTAG_ARB_FRAMING_EN
    exp.push_back(8'hFE); exp.push_back(8'h00);
`endif
    exp.push_back(8'h41);
    iCh0_DATA = 8'h41; iCh0_Valid = 1'b1;
    foreach (exp[i]) begin
      xfer((i == exp.size() - 1) ? 20 : 3, d, w, ok, a);
      if (i == exp.size() - 1) iCh0_Valid = 1'b0;
      nChk++; if (d !== exp[i]) $display("FAIL single data%0d: got %h want %h", i, d, exp[i]); else nPass++;
      nChk++; if (w !== 1) $display("FAIL single latency%0d: got %0d want 1", i, w); else nPass++;
      nChk++; if (ok !== 1'b1) $display("FAIL single start shape%0d: got %b want 1", i, ok); else nPass++;
      nChk++;
      if (a !== ((i == exp.size() - 1) ? 2'b01 : 2'b00))
        $display("FAIL single ack%0d: got %b want %b", i, a, (i == exp.size() - 1) ? 2'b01 : 2'b00);
      else nPass++;
    end
    tick(); tick();
    nChk++;
    if ({oTxD_Start, oCh1_Ack, oCh0_Ack} !== 3'b000)
      $display("FAIL single idle after: got %b want 000", {oTxD_Start, oCh1_Ack, oCh0_Ack});
    else nPass++;
  endtask

  task automatic test_rr();
    logic [7:0] exp[$]; logic [1:0] ackE[$]; logic [7:0] d; int w; logic ok; logic [1:0] a;
    logic c;
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      c = k[0];
`ifdef JTAG_ARB_FRAMING_EN
      exp.push_back(8'hFE);       ackE.push_back(2'b00);
      exp.push_back({7'b0, c});   ackE.push_back(2'b00);
`endif
      exp.push_back(c ? 8'hB1 : 8'hA0);
      ackE.push_back(c ? 2'b10 : 2'b01);
    end
    iCh0_DATA = 8'hA0; iCh1_DATA = 8'hB1;
    iCh0_Valid = 1'b1; iCh1_Valid = 1'b1;
    foreach (exp[i]) begin
      xfer(2, d, w, ok, a);
      nChk++; if (d !== exp[i]) $display("FAIL rr data%0d: got %h want %h", i, d, exp[i]); else nPass++;
      nChk++; if (a !== ackE[i]) $display("FAIL rr ack%0d: got %b want %b", i, a, ackE[i]); else nPass++;
    end
    iCh0_Valid = 1'b0; iCh1_Valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_escape();
    logic [7:0] exp[$]; logic [7:0] d; int w; logic ok; logic [1:0] a;
    pulse_reset();
`ifdef JTAG_ARB_FRAMING_EN
    exp.push_back(8'hFE); exp.push_back(8'h01); exp.push_back(8'hFE);
`endif
    exp.push_back(8'hFE);
    iCh1_DATA = 8'hFE; iCh1_Valid = 1'b1;
    foreach (exp[i]) begin
      xfer(2, d, w, ok, a);
      if (i == exp.size() - 1) iCh1_Valid = 1'b0;
      nChk++; if (d !== exp[i]) $display("FAIL esc data%0d: got %h want %h", i, d, exp[i]); else nPass++;
      nChk++; if (w !== 1 || ok !== 1'b1) $display("FAIL esc gap%0d: wait %0d ok %b want 1 1", i, w, ok); else nPass++;
      nChk++;
      if (a !== ((i == exp.size() - 1) ? 2'b10 : 2'b00))
        $display("FAIL esc ack%0d: got %b want %b", i, a, (i == exp.size() - 1) ? 2'b10 : 2'b00);
      else nPass++;
    end
    tick(); tick();
  endtask

  task automatic test_timeout();
    logic [7:0] exp[$]; logic [7:0] d; int w; logic ok; logic [1:0] a; int k; logic held;
    pulse_reset();
    iCh0_DATA = 8'h11; iCh0_Valid = 1'b1;
`ifdef JTAG_ARB_FRAMING_EN
    for (int i = 0; i < 2; i++) xfer(1, d, w, ok, a);
`endif
    xfer(1, d, w, ok, a);
    nChk++; if (d !== 8'h11 || a !== 2'b01) $display("FAIL to pre byte: data %h ack %b want 11 01", d, a); else nPass++;
    iCh0_DATA = 8'h5A;
    w = 0;
    while (oTxD_Start !== 1'b1 && w < 10) begin tick(); w++; end
    nChk++; if (oTxD_DATA !== 8'h5A) $display("FAIL to stalled byte: got %h want 5a", oTxD_DATA); else nPass++;
    k = 0; held = 1'b1;
    while (oTimeout !== 1'b1 && k < TO + 8) begin
      tick(); k++;
      if (oTimeout !== 1'b1 && oTxD_Start !== 1'b1) held = 1'b0;
    end
    nChk++; if (k !== TO || held !== 1'b1) $display("FAIL to latency: got %0d held %b want %0d 1", k, held, TO); else nPass++;
    nChk++;
    if ({oCh1_Ack, oCh0_Ack, oTxD_Start} !== 3'b010)
      $display("FAIL to ack/start: got %b want 010", {oCh1_Ack, oCh0_Ack, oTxD_Start});
    else nPass++;
    iCh0_DATA = 8'h5B;
`ifdef JTAG_ARB_FRAMING_EN
    exp.push_back(8'hFE); exp.push_back(8'h00);
`endif
    exp.push_back(8'h5B);
    foreach (exp[i]) begin
      xfer(1, d, w, ok, a);
      if (i == exp.size() - 1) iCh0_Valid = 1'b0;
      nChk++; if (d !== exp[i]) $display("FAIL to resend data%0d: got %h want %h", i, d, exp[i]); else nPass++;
    end
    nChk++; if (a !== 2'b01) $display("FAIL to resend ack: got %b want 01", a); else nPass++;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; int w; logic ok; logic [1:0] a;
    pulse_reset();
    iCh0_DATA = 8'h77; iCh0_Valid = 1'b1;
    w = 0;
    while (oTxD_Start !== 1'b1 && w < 10) begin tick(); w++; end
    tick(); tick(); tick();
    iRST_n = 1'b1;
    iCh0_DATA = 8'h88; iCh1_DATA = 8'h99; iCh1_Valid = 1'b1;
    tick();
    nChk++;
    if ({oTxD_Start, oCh1_Ack, oCh0_Ack} !== 3'b000)
      $display("FAIL midreset start/ack: got %b want 000", {oTxD_Start, oCh1_Ack, oCh0_Ack});
    else nPass++;
    iRST_n = 1'b0;
`ifdef JTAG_ARB_FRAMING_EN
    xfer(1, d, w, ok, a);
    xfer(1, d, w, ok, a);
    nChk++; if (d !== 8'h00) $display("FAIL midreset regrant sel: got %h want 00", d); else nPass++;
`else
    xfer(1, d, w, ok, a);
    nChk++; if (d !== 8'h88) $display("FAIL midreset regrant data: got %h want 88", d); else nPass++;
`endif
    iCh0_Valid = 1'b0; iCh1_Valid = 1'b0;
    pulse_reset();
  endtask

  task automatic test_rx();
    logic [7:0] bytes[8] = '{8'hFE, 8'h01, 8'h55, 8'hFE, 8'hFE, 8'hFE, 8'h07, 8'h33};
`ifdef JTAG_ARB_FRAMING_EN
    logic [1:0] vE[8] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
    logic       eE[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    logic [1:0] vE[8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic       eE[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 8; i++) begin
      iRxD_DATA = bytes[i]; iRxD_Ready = 1'b1;
      tick();
      iRxD_Ready = 1'b0;
      nChk++; if (oRx_Valid !== vE[i]) $display("FAIL rx valid%0d: got %b want %b", i, oRx_Valid, vE[i]); else nPass++;
      nChk++; if (oRx_Err !== eE[i]) $display("FAIL rx err%0d: got %b want %b", i, oRx_Err, eE[i]); else nPass++;
      if (vE[i] != 2'b00) begin
        nChk++; if (oRx_DATA !== bytes[i]) $display("FAIL rx data%0d: got %h want %h", i, oRx_DATA, bytes[i]); else nPass++;
      end
      tick();
      nChk++;
      if ({oRx_Valid, oRx_Err} !== 3'b000) $display("FAIL rx pulse%0d: got %b want 000", i, {oRx_Valid, oRx_Err});
      else nPass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_escape();
    test_timeout();
    test_reset_mid();
    test_rx();
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
